// File: rtl/psdi_fir_stereo.sv
`default_nettype none
// ============================================================================
// Module   : psdi_fir_stereo
// Brief    : Stereo time-multiplexed FIR filter. One shared coefficient RAM
//            and one MAC per channel. Includes input conditioning (mute, swap,
//            bypass, delay-line clear), rounding, saturation and an overrun
//            flag.
// Revision : 1.0 - initial release
// ============================================================================
module psdi_fir_stereo #(
    parameter int DW    = 18,
    parameter int CW    = 8,
    parameter int AW    = 7,
    parameter int NTAPS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           switches,
    input  logic                 data_en,
    output logic [AW-1:0]        RAM_coefs_addr,
    input  logic signed [CW-1:0] RAM_coefs_dataout,
    input  logic signed [DW-1:0] left_in,
    input  logic signed [DW-1:0] right_in,
    output logic signed [DW-1:0] left_out,
    output logic signed [DW-1:0] right_out,
    output logic                 busy,
    output logic                 overrun
);

    localparam int c_KW   = $clog2(NTAPS);
    localparam int c_PW   = DW + CW;
    localparam int c_ACCW = DW + CW + $clog2(NTAPS);
    localparam int c_RW   = c_ACCW + 1;
    localparam logic signed [c_RW-1:0] c_RND    = c_RW'(1) << (CW - 2);
    localparam logic signed [c_RW-1:0] c_SAT_HI = (c_RW'(1) << (DW - 1)) - c_RW'(1);
    localparam logic signed [c_RW-1:0] c_SAT_LO = -(c_RW'(1) << (DW - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MAC   = 2'd2,
        S_ROUND = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_KW-1:0]           r_k;
    logic [AW-1:0]             r_addr;
    logic signed [c_ACCW-1:0]  r_acc_l;
    logic signed [c_ACCW-1:0]  r_acc_r;
    logic signed [DW-1:0]      r_out_l;
    logic signed [DW-1:0]      r_out_r;
    logic                      r_busy;
    logic                      r_ovr;
    logic signed [DW-1:0]      r_dl_l [NTAPS];
    logic signed [DW-1:0]      r_dl_r [NTAPS];

    logic signed [DW-1:0]      w_cond_l;
    logic signed [DW-1:0]      w_cond_r;
    logic signed [DW-1:0]      w_tap_l;
    logic signed [DW-1:0]      w_tap_r;
    logic signed [c_PW-1:0]    w_prod_l;
    logic signed [c_PW-1:0]    w_prod_r;
    logic                      w_unused_sw;

    // Mute wins over swap; each channel can independently take the other input
    assign w_cond_l = switches[0] ? '0 : (switches[2] ? right_in : left_in);
    assign w_cond_r = switches[1] ? '0 : (switches[3] ? left_in  : right_in);

    // Coefficient k (arriving this cycle) pairs with tap x[k] on both channels
    assign w_tap_l  = r_dl_l[r_k];
    assign w_tap_r  = r_dl_r[r_k];
    assign w_prod_l = c_PW'(w_tap_l) * c_PW'(RAM_coefs_dataout);
    assign w_prod_r = c_PW'(w_tap_r) * c_PW'(RAM_coefs_dataout);

    assign w_unused_sw = ^switches[6:5];

    // Round half up, then clamp into the DW-bit signed output range
    function automatic logic signed [DW-1:0] f_round_sat(input logic signed [c_ACCW-1:0] acc);
        logic signed [c_RW-1:0] v;
        v = (c_RW'(acc) + c_RND) >>> (CW - 1);
        if (v > c_SAT_HI) begin
            v = c_SAT_HI;
        end else if (v < c_SAT_LO) begin
            v = c_SAT_LO;
        end
        return v[DW-1:0];
    endfunction

    // Sequencer: accept sample, prefetch coefficient, accumulate, round
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_addr  <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_out_l <= '0;
            r_out_r <= '0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (data_en && (r_state != S_IDLE)) begin
                r_ovr <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (data_en) begin
                        r_k     <= '0;
                        r_addr  <= '0;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                        if (switches[4]) begin
                            // Bypass: pass conditioned samples straight through
                            r_out_l <= w_cond_l;
                            r_out_r <= w_cond_r;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_addr  <= AW'(1);
                    r_state <= S_MAC;
                end
                S_MAC: begin
                    r_acc_l <= r_acc_l + c_ACCW'(w_prod_l);
                    r_acc_r <= r_acc_r + c_ACCW'(w_prod_r);
                    r_addr  <= AW'(r_k) + AW'(2);
                    if (r_k == c_KW'(NTAPS - 1)) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                S_ROUND: begin
                    r_out_l <= f_round_sat(r_acc_l);
                    r_out_r <= f_round_sat(r_acc_r);
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay lines: shift on an accepted sample, clear on request while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_dl_l[i] <= '0;
                r_dl_r[i] <= '0;
            end
        end else if (r_state == S_IDLE) begin
            if (data_en) begin
                for (int i = 1; i < NTAPS; i++) begin
                    r_dl_l[i] <= switches[7] ? '0 : r_dl_l[i-1];
                    r_dl_r[i] <= switches[7] ? '0 : r_dl_r[i-1];
                end
                r_dl_l[0] <= w_cond_l;
                r_dl_r[0] <= w_cond_r;
            end else if (switches[7]) begin
                for (int i = 0; i < NTAPS; i++) begin
                    r_dl_l[i] <= '0;
                    r_dl_r[i] <= '0;
                end
            end
        end
    end

    assign RAM_coefs_addr = r_addr;
    assign left_out       = r_out_l;
    assign right_out      = r_out_r;
    assign busy           = r_busy;
    assign overrun        = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_psdi_fir_stereo.sv
`default_nettype none
// ============================================================================
// Module   : tb_psdi_fir_stereo
// Brief    : Self-checking bench for psdi_fir_stereo: table vectors for the
//            conditioning paths, hand sequences for timing/overrun/reset,
//            and randomized samples against a sum-of-products model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psdi_fir_stereo;

    localparam int DW    = 18;
    localparam int CW    = 8;
    localparam int AW    = 7;
    localparam int NTAPS = 32;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic                 clock;
    logic                 reset;
    logic [7:0]           switches;
    logic                 data_en;
    logic [AW-1:0]        RAM_coefs_addr;
    logic signed [CW-1:0] RAM_coefs_dataout;
    logic signed [DW-1:0] left_in;
    logic signed [DW-1:0] right_in;
    logic signed [DW-1:0] left_out;
    logic signed [DW-1:0] right_out;
    logic                 busy;
    logic                 overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [CW-1:0] coef_mem [2**AW];
    int hist_l [NTAPS];
    int hist_r [NTAPS];
    int mdl_out_l;
    int mdl_out_r;

    typedef struct {
        int         l;
        int         r;
        logic [7:0] sw;
        int         el;
        int         er;
    } vec_t;
    vec_t tbl [8];

    psdi_fir_stereo #(.DW(DW), .CW(CW), .AW(AW), .NTAPS(NTAPS)) dut (
        .clock             (clock),
        .reset             (reset),
        .switches          (switches),
        .data_en           (data_en),
        .RAM_coefs_addr    (RAM_coefs_addr),
        .RAM_coefs_dataout (RAM_coefs_dataout),
        .left_in           (left_in),
        .right_in          (right_in),
        .left_out          (left_out),
        .right_out         (right_out),
        .busy              (busy),
        .overrun           (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read coefficient RAM
    always @(posedge clock) RAM_coefs_dataout <= coef_mem[RAM_coefs_addr];

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        n_cmp++;
        if (act !== 64'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_coefs(input int v);
        for (int i = 0; i < 2**AW; i++) coef_mem[i] = CW'(v);
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < NTAPS; i++) begin
            hist_l[i] = 0;
            hist_r[i] = 0;
        end
    endtask

    task automatic mdl_reset();
        mdl_clear();
        mdl_out_l = 0;
        mdl_out_r = 0;
    endtask

    function automatic int mdl_fir(input bit right);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++)
            acc += longint'(coef_mem[k]) * longint'(right ? hist_r[k] : hist_l[k]);
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (acc > MAXV) acc = MAXV;
        if (acc < MINV) acc = MINV;
        return int'(acc);
    endfunction

    task automatic mdl_accept(input int l, input int r, input logic [7:0] sw,
                              output int el, output int er, output bit byp);
        int cl;
        int cr;
        cl = sw[0] ? 0 : (sw[2] ? r : l);
        cr = sw[1] ? 0 : (sw[3] ? l : r);
        if (sw[7]) mdl_clear();
        for (int i = NTAPS - 1; i > 0; i--) begin
            hist_l[i] = hist_l[i-1];
            hist_r[i] = hist_r[i-1];
        end
        hist_l[0] = cl;
        hist_r[0] = cr;
        byp = sw[4];
        if (byp) begin
            el = cl;
            er = cr;
        end else begin
            el = mdl_fir(1'b0);
            er = mdl_fir(1'b1);
        end
        mdl_out_l = el;
        mdl_out_r = er;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mdl_reset();
    endtask

    // One sample: strobe, then follow busy/address/hold timing and compare
    // the result. Returns half a cycle after the output edge.
    task automatic do_sample(input int l, input int r, input logic [7:0] sw, input string tag);
        int  el;
        int  er;
        bit  byp;
        int  old_l;
        int  old_r;
        bit  bad;
        int  bad_j;
        old_l = mdl_out_l;
        old_r = mdl_out_r;
        @(negedge clock);
        left_in  = DW'(l);
        right_in = DW'(r);
        switches = sw;
        data_en  = 1'b1;
        mdl_accept(l, r, sw, el, er, byp);
        @(negedge clock);
        data_en  = 1'b0;
        switches = sw & 8'h7F;
        if (byp) begin
            check({tag, "_byp_busy"}, busy, 0);
            check({tag, "_byp_l"}, left_out, el);
            check({tag, "_byp_r"}, right_out, er);
        end else begin
            bad   = 1'b0;
            bad_j = -1;
            for (int j = 0; j < NTAPS + 2; j++) begin
                if (busy !== 1'b1) bad = 1'b1;
                if (j < NTAPS && RAM_coefs_addr !== AW'(j)) bad = 1'b1;
                if (j == NTAPS + 1 && (left_out !== DW'(old_l) || right_out !== DW'(old_r))) bad = 1'b1;
                if (bad && bad_j < 0) bad_j = j;
                if (j == 2) switches = 8'($urandom) & 8'h6F;
                @(negedge clock);
            end
            check({tag, "_timing_first_bad_cycle"}, bad_j, -1);
            check({tag, "_busy_end"}, busy, 0);
            check({tag, "_addr_end"}, RAM_coefs_addr, 0);
            check({tag, "_l"}, left_out, el);
            check({tag, "_r"}, right_out, er);
        end
    endtask

    task automatic impulse_run(input string tag);
        do_sample(1000, 0, 8'h00, tag);
        check({tag, "_imp0_l"}, left_out, 500);
        for (int i = 1; i <= NTAPS; i++) begin
            do_sample(0, 0, 8'h00, tag);
            check({tag, "_imp_l"}, left_out, (i < NTAPS) ? 500 : 0);
            check({tag, "_imp_r"}, right_out, 0);
        end
    endtask

    initial begin
        tbl[0] = '{l: 100,     r: 200, sw: 8'h10, el: 100,     er: 200};
        tbl[1] = '{l: 5,       r: 777, sw: 8'h14, el: 777,     er: 777};
        tbl[2] = '{l: 5,       r: 777, sw: 8'h15, el: 0,       er: 777};
        tbl[3] = '{l: -300,    r: 42,  sw: 8'h18, el: -300,    er: -300};
        tbl[4] = '{l: -300,    r: 42,  sw: 8'h1C, el: 42,      er: -300};
        tbl[5] = '{l: 131071,  r: 9,   sw: 8'h12, el: 131071,  er: 0};
        tbl[6] = '{l: 1,       r: 2,   sw: 8'h13, el: 0,       er: 0};
        tbl[7] = '{l: -131072, r: -1,  sw: 8'h90, el: -131072, er: -1};

        reset    = 1'b1;
        switches = 8'h00;
        data_en  = 1'b0;
        left_in  = '0;
        right_in = '0;
        set_coefs(64);
        mdl_reset();

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_left_out", left_out, 0);
        check("rst_right_out", right_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_addr", RAM_coefs_addr, 0);
        reset = 1'b0;

        // Impulse response with half-scale coefficients
        impulse_run("impulse");

        // Conditioning paths through bypass
        for (int i = 0; i < 8; i++) begin
            do_sample(tbl[i].l, tbl[i].r, tbl[i].sw, "tbl");
            check($sformatf("tbl%0d_l", i), left_out, tbl[i].el);
            check($sformatf("tbl%0d_r", i), right_out, tbl[i].er);
        end
        // Leaving bypass: outputs hold until the filtered result lands
        do_sample(300, -400, 8'h00, "unbypass");

        // Idle clear of the delay lines
        @(negedge clock);
        switches = 8'h80;
        repeat (2) @(negedge clock);
        switches = 8'h00;
        mdl_clear();
        do_sample(1000, -1000, 8'h00, "clear");
        check("clear_l", left_out, 500);
        check("clear_r", right_out, -500);

        // Saturation
        do_reset();
        set_coefs(127);
        for (int i = 0; i < NTAPS; i++) do_sample(131071, 0, 8'h00, "satp");
        check("sat_pos_l", left_out, 131071);
        for (int i = 0; i < NTAPS; i++) do_sample(-131072, 0, 8'h00, "satn");
        check("sat_neg_l", left_out, -131072);

        // Overrun: second strobe 5 cycles into a computation
        do_reset();
        set_coefs(64);
        check("ovr_initial", overrun, 0);
        begin
            int  el;
            int  er;
            bit  byp;
            @(negedge clock);
            left_in = DW'(1000);
            right_in = '0;
            switches = 8'h00;
            data_en = 1'b1;
            mdl_accept(1000, 0, 8'h00, el, er, byp);
            @(negedge clock);
            data_en = 1'b0;
            repeat (4) @(negedge clock);
            left_in = DW'(5000);
            data_en = 1'b1;
            @(negedge clock);
            data_en = 1'b0;
            check("ovr_set", overrun, 1);
            repeat (29) @(negedge clock);
            check("ovr_result_l", left_out, 500);
            check("ovr_result_r", right_out, 0);
            check("ovr_busy_after", busy, 0);
            check("ovr_sticky", overrun, 1);
        end

        // Reset in the middle of a computation
        do_sample(1000, 0, 8'h00, "prerst");
        @(negedge clock);
        left_in = DW'(3000);
        data_en = 1'b1;
        @(negedge clock);
        data_en = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_left_out", left_out, 0);
        check("midrst_right_out", right_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_addr", RAM_coefs_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        mdl_reset();
        impulse_run("postrst");

        // Randomized samples and coefficient sets
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < NTAPS; i++) coef_mem[i] = CW'($urandom);
            for (int n = 0; n < 15; n++) begin
                int         l;
                int         r;
                logic [7:0] sw;
                l  = int'($urandom_range(0, 2**DW - 1)) - 2**(DW - 1);
                r  = int'($urandom_range(0, 2**DW - 1)) - 2**(DW - 1);
                sw = {($urandom_range(0, 9) == 0), 2'b00, ($urandom_range(0, 4) == 0), 4'($urandom)};
                do_sample(l, r, sw, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
